// File: rtl/blackjack_round_sequencer_pkg.sv
// Shared types and rule defaults for the blackjack round datapath.
package blackjack_pkg;

   localparam int DEALER_STAND_DFLT = 17;
   localparam int BUST_LIMIT_DFLT   = 21;
   localparam int MAX_CARDS_DFLT    = 5;

   typedef logic [3:0] card;
   typedef logic [4:0] hand;

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      DEAL_P1,
      DEAL_D1,
      DEAL_P2,
      DEAL_D2,
      CHECK_NATURAL,
      PLAYER_TURN,
      DEALER_TURN,
      SETTLE,
      DONE
   } gameState;

   typedef enum logic [1:0] {TURN_NONE, TURN_PLAYER, TURN_DEALER} turnIndicator;
   typedef enum logic [1:0] {RES_NONE, RES_PLAYER, RES_DEALER, RES_PUSH} result;
   typedef enum logic {DEST_PLAYER, DEST_DEALER} fetchDest;

endpackage

// File: rtl/blackjack_round_sequencer_if.sv
// Handshake bundle between the round sequencer and the deck, hands, user input and display.
interface blackjack_round_sequencer_if;
   import blackjack_pkg::*;

   logic         i_start;
   logic         i_playerValid;
   logic         i_playerHit;
   logic         i_deckValid;
   card          i_deckCard;
   hand          i_playerSum;
   hand          i_dealerSum;
   logic [2:0]   i_playerCount;
   logic [2:0]   i_dealerCount;

   logic         o_deckReq;
   card          o_card;
   logic         o_playerLoad;
   logic         o_dealerLoad;
   logic         o_handClear;
   logic         o_holeHidden;
   turnIndicator o_turn;
   gameState     o_state;
   result        o_result;

   modport master (
      input  i_start, i_playerValid, i_playerHit, i_deckValid, i_deckCard,
             i_playerSum, i_dealerSum, i_playerCount, i_dealerCount,
      output o_deckReq, o_card, o_playerLoad, o_dealerLoad, o_handClear,
             o_holeHidden, o_turn, o_state, o_result
   );

   modport slave (
      output i_start, i_playerValid, i_playerHit, i_deckValid, i_deckCard,
             i_playerSum, i_dealerSum, i_playerCount, i_dealerCount,
      input  o_deckReq, o_card, o_playerLoad, o_dealerLoad, o_handClear,
             o_holeHidden, o_turn, o_state, o_result
   );

endinterface

// File: rtl/blackjack_round_sequencer_card_fetch_unit.sv
// One-card fetch: hold the deck request, capture the card, strobe the chosen hand, allow one settle cycle.
//  state    | meaning
//  F_IDLE   | no fetch in flight
//  F_REQ    | o_deckReq high, waiting for i_deckValid
//  F_LOAD   | card and load strobe presented to the hand
//  F_SETTLE | hand sums valid; o_done high, a new fetch may launch
module card_fetch_unit
   import blackjack_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_reset,
   input  logic     i_start,
   input  fetchDest i_dest,
   input  logic     i_deckValid,
   input  card      i_deckCard,
   output logic     o_deckReq,
   output card      o_card,
   output logic     o_playerLoad,
   output logic     o_dealerLoad,
   output logic     o_busy,
   output logic     o_done
);

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_LOAD, F_SETTLE} fetchState;

   fetchState fState;
   fetchDest  destQ;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fState       <= F_IDLE;
         destQ        <= DEST_PLAYER;
         o_deckReq    <= 1'b0;
         o_card       <= '0;
         o_playerLoad <= 1'b0;
         o_dealerLoad <= 1'b0;
      end else begin
         o_playerLoad <= 1'b0;
         o_dealerLoad <= 1'b0;
         case (fState)
            F_IDLE, F_SETTLE: begin
               if (i_start) begin
                  o_deckReq <= 1'b1;
                  destQ     <= i_dest;
                  fState    <= F_REQ;
               end else begin
                  fState    <= F_IDLE;
               end
            end
            F_REQ: begin
               if (i_deckValid) begin
                  o_card       <= i_deckCard;
                  o_deckReq    <= 1'b0;
                  o_playerLoad <= (destQ == DEST_PLAYER);
                  o_dealerLoad <= (destQ == DEST_DEALER);
                  fState       <= F_LOAD;
               end
            end
            F_LOAD:  fState <= F_SETTLE;
            default: fState <= F_IDLE;
         endcase
      end
   end

   assign o_busy = (fState != F_IDLE);
   assign o_done = (fState == F_SETTLE);

endmodule

// File: rtl/blackjack_round_sequencer.sv
// Round controller: owns the deck fetch, sequences deal, player turn, dealer turn and settlement.
//  state         | meaning
//  IDLE          | waiting for i_start after reset
//  CLEAR         | hands cleared, first deal fetch launched
//  DEAL_P1..D2   | one card each, alternating player/dealer
//  CHECK_NATURAL | resolve two-card 21s
//  PLAYER_TURN   | accept hit/stand from the player
//  DEALER_TURN   | dealer draws below the stand value, then compare
//  SETTLE        | result latched, hole card revealed
//  DONE          | result held until the next i_start
module blackjack_round_sequencer
   import blackjack_pkg::*;
#(
   parameter int DEALER_STAND = DEALER_STAND_DFLT,
   parameter int BUST_LIMIT   = BUST_LIMIT_DFLT,
   parameter int MAX_CARDS    = MAX_CARDS_DFLT
) (
   input logic                          i_clk,
   input logic                          i_reset,
   blackjack_round_sequencer_if.master  bus
);

   localparam hand        STAND = hand'(DEALER_STAND);
   localparam hand        BUST  = hand'(BUST_LIMIT);
   localparam logic [2:0] FULL  = 3'(MAX_CARDS);
   localparam logic [2:0] TWO   = 3'd2;

   gameState     state;
   turnIndicator turn;
   result        res;
   logic         handClear;
   logic         holeHidden;

   logic     fetchStart;
   fetchDest fetchSel;
   logic     fetchBusy;
   logic     fetchDone;
   logic     fetchReady;
   logic     finish;
   result    finishRes;

   logic playerNat, dealerNat, dealerDraws, standReq;

   card_fetch_unit fetch (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (fetchStart),
      .i_dest       (fetchSel),
      .i_deckValid  (bus.i_deckValid),
      .i_deckCard   (bus.i_deckCard),
      .o_deckReq    (bus.o_deckReq),
      .o_card       (bus.o_card),
      .o_playerLoad (bus.o_playerLoad),
      .o_dealerLoad (bus.o_dealerLoad),
      .o_busy       (fetchBusy),
      .o_done       (fetchDone)
   );

   // Sums are only trusted when no fetch is in flight or the last card has just settled.
   assign fetchReady  = !fetchBusy || fetchDone;
   assign playerNat   = (bus.i_playerSum == BUST) && (bus.i_playerCount == TWO);
   assign dealerNat   = (bus.i_dealerSum == BUST) && (bus.i_dealerCount == TWO);
   assign dealerDraws = (bus.i_dealerSum < STAND) && (bus.i_dealerCount < FULL);
   assign standReq    = !fetchBusy && bus.i_playerValid && !bus.i_playerHit;

   // Fetch launches are decoded from the current state so the request rises on the entry edge.
   always_comb begin
      fetchStart = 1'b0;
      fetchSel   = DEST_PLAYER;
      finish     = 1'b0;
      finishRes  = RES_NONE;
      case (state)
         CLEAR:   fetchStart = 1'b1;
         DEAL_P1: begin fetchStart = fetchDone; fetchSel = DEST_DEALER; end
         DEAL_D1: fetchStart = fetchDone;
         DEAL_P2: begin fetchStart = fetchDone; fetchSel = DEST_DEALER; end
         CHECK_NATURAL: begin
            finish = playerNat || dealerNat;
            if (playerNat && dealerNat) finishRes = RES_PUSH;
            else if (playerNat)         finishRes = RES_PLAYER;
            else                        finishRes = RES_DEALER;
         end
         PLAYER_TURN: begin
            fetchStart = !fetchBusy && bus.i_playerValid && bus.i_playerHit;
            if (fetchDone && bus.i_playerSum > BUST) begin
               finish    = 1'b1;
               finishRes = RES_DEALER;
            end else if (fetchDone && bus.i_playerCount == FULL) begin
               finish    = 1'b1;
               finishRes = RES_PLAYER;
            end
         end
         DEALER_TURN: begin
            fetchSel   = DEST_DEALER;
            fetchStart = fetchReady && dealerDraws;
            finish     = fetchReady && !dealerDraws;
            if (bus.i_dealerSum > BUST)                   finishRes = RES_PLAYER;
            else if (bus.i_playerSum > bus.i_dealerSum)   finishRes = RES_PLAYER;
            else if (bus.i_playerSum < bus.i_dealerSum)   finishRes = RES_DEALER;
            else                                          finishRes = RES_PUSH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         turn       <= TURN_NONE;
         res        <= RES_NONE;
         handClear  <= 1'b0;
         holeHidden <= 1'b0;
      end else begin
         handClear <= 1'b0;
         if (finish) begin
            state      <= SETTLE;
            res        <= finishRes;
            turn       <= TURN_NONE;
            holeHidden <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (bus.i_start) begin
                     state      <= CLEAR;
                     handClear  <= 1'b1;
                     holeHidden <= 1'b1;
                     res        <= RES_NONE;
                     turn       <= TURN_NONE;
                  end
               end
               CLEAR:   state <= DEAL_P1;
               DEAL_P1: if (fetchDone) state <= DEAL_D1;
               DEAL_D1: if (fetchDone) state <= DEAL_P2;
               DEAL_P2: if (fetchDone) state <= DEAL_D2;
               DEAL_D2: if (fetchDone) state <= CHECK_NATURAL;
               CHECK_NATURAL: begin
                  state <= PLAYER_TURN;
                  turn  <= TURN_PLAYER;
               end
               PLAYER_TURN: begin
                  if ((fetchDone && bus.i_playerSum == BUST) || standReq) begin
                     state      <= DEALER_TURN;
                     turn       <= TURN_DEALER;
                     holeHidden <= 1'b0;
                  end
               end
               SETTLE:  state <= DONE;
               default: ;
            endcase
         end
      end
   end

   assign bus.o_state      = state;
   assign bus.o_turn       = turn;
   assign bus.o_result     = res;
   assign bus.o_handClear  = handClear;
   assign bus.o_holeHidden = holeHidden;

endmodule
